// File: rtl/stream_capture_ram_pkg.sv
// stream_capture_ram_pkg: shared types and helpers for the marker-terminated
// capture buffer (stream_capture_ram and its sdp_bram memory).
package stream_capture_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PLAY    = 2'd2
    } state_e;

    // Address width for a buffer of the given depth (never below one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_capture_ram_sdp_bram.sv
// sdp_bram: simple dual-port memory, one write port and one registered read
// port (1-cycle read latency). The read register only updates on rd_en_i so
// the last read word stays available while the consumer stalls.
module sdp_bram
    import stream_capture_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_capture_ram.sv
// stream_capture_ram: captures a valid/ready word stream into block RAM until
// MARKER arrives (or DEPTH words are stored), then plays the frame back with
// out_last on the final word. Optional replay of the retained frame is built
// when STREAM_CAPTURE_RAM_REPLAY_EN is defined.
//
// Read path: p0 issues the RAM read, p1 is the RAM output register, then a
// two-entry output stage (head register + skid) absorbs backpressure. Reads
// are only issued while head + skid + in-flight stays within two entries.
// The read of word 0 is issued in the terminating capture cycle itself; when
// that word is being written in the same cycle it is bypassed from in_data.
module stream_capture_ram
    import stream_capture_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] MARKER     = DATA_WIDTH'(16'hAABB)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    input  logic                     replay,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   length
);

    localparam int AW = addr_width(DEPTH);

    state_e              state_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                overflow_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW:0]         rd_ptr_q;
    logic [AW:0]         length_q;

    logic                vld_p1_q;
    logic                last_p1_q;
    logic                byp_p1_q;
    logic [DATA_WIDTH-1:0] byp_data_p1_q;

    logic                out_valid_q;
    logic                out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                skid_valid_q;
    logic                skid_last_q;
    logic [DATA_WIDTH-1:0] skid_data_q;

    logic                wr_hs;
    logic                is_marker;
    logic                term;
    logic [AW:0]         len_term;
    logic [AW:0]         len_next;
    logic                replay_go;
    logic                start_play;
    logic                pop;
    logic [1:0]          occ;
    logic                credit_ok;
    logic                play_issue;
    logic                byp_p0;
    logic                vld_p0;
    logic                last_p0;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] data_p1;

    // Capture side: a frame ends on the marker or on the last free entry.
    // Either way the frame length is wr_ptr+1 (DEPTH when full).
    assign wr_hs     = in_valid && in_ready_q;
    assign is_marker = (in_data == MARKER);
    assign term      = wr_hs && (is_marker || (wr_ptr_q == AW'(DEPTH - 1)));
    assign len_term  = {1'b0, wr_ptr_q} + (AW + 1)'(1);
    assign len_next  = term ? len_term : length_q;

`ifdef STREAM_CAPTURE_RAM_REPLAY_EN
    assign replay_go = (state_q == ST_IDLE) && replay && !start && (length_q != '0);
`else
    logic unused_replay;
    assign unused_replay = replay;
    assign replay_go     = 1'b0;
`endif

    assign start_play = term || replay_go;

    // Read issue: word 0 on entry to PLAY, then one word per credit.
    assign pop        = out_valid_q && out_ready;
    assign occ        = 2'(out_valid_q) + 2'(skid_valid_q);
    assign credit_ok  = (3'(occ) + 3'(vld_p1_q)) < (3'd2 + 3'(pop));
    assign play_issue = (state_q == ST_PLAY) && (rd_ptr_q < length_q) && credit_ok;
    assign byp_p0     = term && (wr_ptr_q == '0);
    assign vld_p0     = start_play || play_issue;
    assign rd_en      = (start_play && !byp_p0) || play_issue;
    assign rd_addr    = start_play ? '0 : rd_ptr_q[AW-1:0];
    assign last_p0    = start_play ? (len_next == (AW + 1)'(1))
                                   : ((rd_ptr_q + (AW + 1)'(1)) == length_q);

    sdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i      (clk),
        .wr_en_i    (wr_hs),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (in_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (ram_rd_data)
    );

    // Control FSM: state, pointers, frame length and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            length_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CAPTURE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        wr_ptr_q   <= '0;
                        overflow_q <= 1'b0;
                    end else if (replay_go) begin
                        state_q  <= ST_PLAY;
                        busy_q   <= 1'b1;
                        rd_ptr_q <= (AW + 1)'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (wr_hs) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                    end
                    if (term) begin
                        state_q    <= ST_PLAY;
                        in_ready_q <= 1'b0;
                        length_q   <= len_term;
                        overflow_q <= !is_marker;
                        rd_ptr_q   <= (AW + 1)'(1);
                    end
                end
                ST_PLAY: begin
                    if (play_issue) begin
                        rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
                    end
                    if (pop && out_last_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // p0 -> p1: track which RAM reads are in flight and whether they are last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            byp_p1_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p0;
            last_p1_q <= last_p0;
            byp_p1_q  <= byp_p0;
        end
    end

    // p0 -> p1: hold word 0 when it is written in the terminating cycle.
    always_ff @(posedge clk) begin
        if (byp_p0) begin
            byp_data_p1_q <= in_data;
        end
    end

    assign data_p1 = byp_p1_q ? byp_data_p1_q : ram_rd_data;

    // p1 -> output: head register plus skid entry for backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_last_q   <= skid_last_q;
                skid_valid_q <= vld_p1_q;
                if (vld_p1_q) begin
                    skid_data_q <= data_p1;
                    skid_last_q <= last_p1_q;
                end
            end else begin
                out_valid_q <= vld_p1_q;
                out_last_q  <= vld_p1_q && last_p1_q;
                if (vld_p1_q) begin
                    out_data_q <= data_p1;
                end
            end
        end else if (vld_p1_q) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= data_p1;
            skid_last_q  <= last_p1_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign length    = length_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_capture_ram.sv
// tb_stream_capture_ram: directed bench for stream_capture_ram (DEPTH=8).
// Replay behaviour is checked in the form matching STREAM_CAPTURE_RAM_REPLAY_EN.
module tb_stream_capture_ram;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          replay;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] length;

    int n_total = 0;
    int n_pass  = 0;
    int accepted;

    logic [DW-1:0] stim_q [$];
    int            gap_q  [$];
    logic [DW-1:0] exp_q  [$];

    stream_capture_ram #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MARKER     (16'hAABB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .replay    (replay),
        .busy      (busy),
        .overflow  (overflow),
        .length    (length)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
        check({tag, "_length"},    32'(length),    32'd0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Offer every word of stim_q; words seen with in_ready high are expected back.
    task automatic feed();
        accepted = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            int ng;
            ng = (i < gap_q.size()) ? gap_q[i] : 0;
            for (int g = 0; g < ng; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 16'hBAD0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stim_q[i];
            if (in_ready) begin
                exp_q.push_back(stim_q[i]);
                accepted++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Consume exp_q.size() words, checking order, out_last and stall stability.
    task automatic drain(input bit toggle, input string tag);
        int            k = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [DW-1:0] held = '0;
        while (k < exp_q.size() && cyc < 200) begin
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled) begin
                check({tag, "_stall_vld"},  32'(out_valid), 32'd1);
                check({tag, "_stall_data"}, 32'(out_data),  32'(held));
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_data%0d", tag, k), 32'(out_data), 32'(exp_q[k]));
                check($sformatf("%s_last%0d", tag, k), 32'(out_last),
                      32'(k == exp_q.size() - 1));
                k++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end else begin
                stalled = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_count"},    32'(k),         32'(exp_q.size()));
        check({tag, "_done_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_done_busy"},32'(busy),      32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        replay    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Basic frame with the consumer always ready.
        exp_q.delete();
        gap_q.delete();
        stim_q    = '{16'h1111, 16'h2222, 16'h3333, 16'hAABB};
        out_ready = 1'b1;
        start_pulse();
        check("b_busy_cap", 32'(busy), 32'd1);
        feed();
        check("b_len",       32'(length),    32'd4);
        check("b_ovf",       32'(overflow),  32'd0);
        check("b_in_rdy",    32'(in_ready),  32'd0);
        check("b_vld_early", 32'(out_valid), 32'd0);
        check("b_busy_play", 32'(busy),      32'd1);
        @(negedge clk);
        check("b_vld_lat2",  32'(out_valid), 32'd1);
        drain(1'b0, "basic");
        check("b_len_hold",  32'(length),    32'd4);

        // Same frame, consumer ready every other cycle.
        exp_q.delete();
        out_ready = 1'b0;
        start_pulse();
        feed();
        drain(1'b1, "tog");

        // Reset in the middle of a capture, then a short frame.
        exp_q.delete();
        stim_q = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0C05};
        start_pulse();
        feed();
        check("r_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        stim_q    = '{16'h0A0A, 16'h0B0B, 16'hAABB};
        out_ready = 1'b1;
        start_pulse();
        feed();
        check("r_len", 32'(length), 32'd3);
        drain(1'b0, "rst");

        // Ten non-marker words into an 8-entry buffer.
        exp_q.delete();
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back(16'h0100 + 16'(i));
        out_ready = 1'b0;
        start_pulse();
        feed();
        check("ovf_accepted", 32'(accepted), 32'd8);
        check("ovf_in_rdy",   32'(in_ready), 32'd0);
        check("ovf_flag",     32'(overflow), 32'd1);
        check("ovf_len",      32'(length),   32'd8);
        drain(1'b0, "ovf");
        check("ovf_flag_hold", 32'(overflow), 32'd1);

        // Single-word frame: the marker alone.
        exp_q.delete();
        stim_q = '{16'hAABB};
        start_pulse();
        check("one_ovf_clr", 32'(overflow), 32'd0);
        feed();
        check("one_len", 32'(length), 32'd1);
        drain(1'b0, "one");

        // in_valid before start is ignored; gaps during capture store nothing.
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_rdy", 32'(in_ready), 32'd0);
        end
        start_pulse();
        stim_q = '{16'h5555, 16'h6666, 16'hAABB};
        gap_q  = '{0, 1, 2};
        feed();
        gap_q.delete();
        check("gap_accepted", 32'(accepted), 32'd3);
        check("gap_len",      32'(length),   32'd3);
        drain(1'b0, "gap");

`ifdef STREAM_CAPTURE_RAM_REPLAY_EN
        // Replay re-emits the retained frame.
        @(negedge clk);
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        check("rep_busy", 32'(busy), 32'd1);
        drain(1'b0, "rep");
        check("rep_len", 32'(length), 32'd3);
        // start beats replay in the same cycle.
        @(negedge clk);
        start  = 1'b1;
        replay = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        replay = 1'b0;
        check("sr_in_rdy", 32'(in_ready), 32'd1);
        exp_q.delete();
        stim_q = '{16'h7777, 16'hAABB};
        feed();
        check("sr_len", 32'(length), 32'd2);
        drain(1'b0, "sr");
`else
        // Replay has no effect in this build.
        @(negedge clk);
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        check("norep_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("norep_vld",   32'(out_valid), 32'd0);
        check("norep_len",   32'(length),    32'd3);
        check("norep_in_rdy",32'(in_ready),  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
